move_input_ctrl: RTL and testbench
==================================

# move_input_ctrl

Front-end input stage that sits directly upstream of the game logic and display path. It synchronizes and debounces the move button (BtnU) and synchronizes the one-hot Row/Col switch banks. On each debounced button press it validates the switches and encodes them to 3-bit indices. It then presents exactly one move per press over a valid/ready handshake, and pulses an error with a reason code when either switch bank is not one-hot.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized button level must differ from the debounced level before it is accepted (10 ms at 100 MHz); must be ≥2.
- DB_CNT_W, 20, debounce counter width; must satisfy 2^DB_CNT_W ≥ DEBOUNCE_CYCLES.
- clk  in  1  system clock, 100 MHz, all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- BtnU  in  1  raw move button, asynchronous to clk, bouncy.
- Row  in  8  raw row switch bank {Sw15..Sw8}, expected one-hot.
- Col  in  8  raw column switch bank {Sw7..Sw0}, expected one-hot.
- move_valid  out  1  move available; held until accepted.
- move_ready  in  1  downstream accepts the move when high with move_valid.
- move_row  out  3  encoded row index (bit position of the set Row bit).
- move_col  out  3  encoded column index.
- err_pulse  out  1  one-cycle pulse: the press had an invalid switch pattern.
- err_code  out  2  valid with err_pulse, holds until the next error; bit0 = Row not one-hot, bit1 = Col not one-hot.
- move_count  out  8  accepted-move counter, saturates at 255.
- busy  out  1  high in any state other than IDLE.

## Operation
- Synchronizers: BtnU passes through a 2-flop synchronizer. Row and Col each pass through their own 2-flop, 8-bit synchronizer.
- Debounce:
  - btn_db is the debounced level. cnt increments each cycle btn_sync ≠ btn_db and clears to 0 on any cycle they are equal.
  - When cnt = DEBOUNCE_CYCLES−1 and they still differ, btn_db ← btn_sync and cnt ← 0.
  - Glitches shorter than DEBOUNCE_CYCLES never change btn_db.
- Edge detect: btn_db_q is btn_db delayed one cycle; press = btn_db & ~btn_db_q.
- One-hot check: a bank is valid iff exactly one bit is set. Zero or ≥2 set bits are invalid. The index is the position of the set bit (Row[0] → 0, Row[7] → 7).
- FSM:
  - IDLE: on press with both banks valid, register move_row/move_col from the synchronized switches sampled on the press cycle and go to PEND. On press with either bank invalid, assert err_pulse, load err_code, go to WAIT_REL.
  - PEND: move_valid = 1 and move_row/move_col are frozen. On move_valid & move_ready, increment move_count (unless 255) and go to WAIT_REL. Switch changes and further presses are ignored.
  - WAIT_REL: go to IDLE on the first cycle btn_db = 0. This guarantees one move per press.
- Reset (async, any state, including mid-debounce or mid-handshake): FSM → IDLE, counters and synchronizer flops → 0. All outputs reset to 0: move_valid, move_row, move_col, err_pulse, err_code, move_count, busy.

## Timing
- Press latency: BtnU held high from clock edge k gives btn_sync = 1 at edge k+2, btn_db = 1 at edge k+2+DEBOUNCE_CYCLES, and move_valid = 1 at edge k+3+DEBOUNCE_CYCLES. err_pulse uses the same latency.
- Switches must be stable for 2 cycles before the press cycle to be captured.
- Handshake: move_valid rises only from IDLE and never drops without move_ready. Acceptance occurs in the cycle both are high. move_valid = 0 on the following cycle, and move_count updates that same following cycle.
- move_ready high while move_valid is low has no effect.
- err_pulse is exactly 1 cycle wide, and at most one per press.
- Release latency: btn_db falls DEBOUNCE_CYCLES+2 cycles after BtnU is stably low. WAIT_REL → IDLE occurs on that cycle.
- move_count at 255: acceptance still completes, and the count stays 255.

## Test plan
- Valid move: DEBOUNCE_CYCLES=4, Row=8'h04, Col=8'h80, BtnU high from edge 10, move_ready=1 → move_valid high at edge 17 for 1 cycle, move_row=2, move_col=7, move_count=1.
- Bounce rejection: BtnU toggles with high pulses of 1–3 cycles, then holds high → exactly one move_valid assertion, timed from the start of the stable-high interval.
- Invalid switches: Row=8'h00, Col=8'h03, press → err_pulse for 1 cycle, err_code=2'b11, no move_valid, move_count unchanged.
- Backpressure: move_ready=0 for 20 cycles after move_valid rises while the switches change → move_valid and the indices stay frozen, then one acceptance when move_ready=1.
- Hold/saturation: keep BtnU high across acceptance → no second move until release and a new press. Perform 256 valid presses → move_count=255.
- Async reset: deassert Reset_n while in PEND → all outputs 0 immediately without waiting for a clock edge. A new press after release works normally.

Source files
------------

// File: rtl/move_input_ctrl.sv
// Move-button front end: synchronizes/debounces BtnU, validates the one-hot Row/Col
// switch banks and hands exactly one encoded move per press downstream over valid/ready.
module move_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_CNT_W        = 20
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       BtnU,
  input  logic [7:0] Row,
  input  logic [7:0] Col,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [2:0] move_row,
  output logic [2:0] move_col,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic [7:0] move_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PEND     = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_CNT_W-1:0] DB_ONE  = DB_CNT_W'(1);

  // {valid, index}: valid only when exactly one bit of the bank is set
  function automatic logic [3:0] onehot_enc(input logic [7:0] v);
    logic [3:0] ones;
    logic [2:0] idx;
    ones = 4'd0;
    idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        ones = ones + 4'd1;
        idx  = 3'(i);
      end else begin
        ones = ones;
      end
    end
    return {(ones == 4'd1), idx};
  endfunction

  logic                r_btn_s1, r_btn_s2;
  logic [7:0]          r_row_s1, r_row_s2;
  logic [7:0]          r_col_s1, r_col_s2;
  logic [DB_CNT_W-1:0] r_db_cnt;
  logic                r_btn_db, r_btn_db_q;
  state_t              r_state;
  logic                r_valid;
  logic [2:0]          r_row, r_col;
  logic                r_err_pulse;
  logic [1:0]          r_err_code;
  logic [7:0]          r_count;
  logic                r_busy;

  logic                w_press;
  logic [3:0]          w_row_enc, w_col_enc;

  // two-flop synchronizers for the button and both switch banks
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_row_s1 <= 8'd0;
      r_row_s2 <= 8'd0;
      r_col_s1 <= 8'd0;
      r_col_s2 <= 8'd0;
    end else begin
      r_btn_s1 <= BtnU;
      r_btn_s2 <= r_btn_s1;
      r_row_s1 <= Row;
      r_row_s2 <= r_row_s1;
      r_col_s1 <= Col;
      r_col_s2 <= r_col_s1;
    end
  end

  // debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_db_cnt   <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
    end else begin
      r_btn_db_q <= r_btn_db;
      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt <= '0;
        r_btn_db <= r_btn_s2;
      end else begin
        r_db_cnt <= r_db_cnt + DB_ONE;
      end
    end
  end

  // press edge and bank validation on the synchronized switches
  always_comb begin
    w_press   = r_btn_db & ~r_btn_db_q;
    w_row_enc = onehot_enc(r_row_s2);
    w_col_enc = onehot_enc(r_col_s2);
  end

  // move FSM with all outputs registered
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_row       <= 3'd0;
      r_col       <= 3'd0;
      r_err_pulse <= 1'b0;
      r_err_code  <= 2'd0;
      r_count     <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_press && w_row_enc[3] && w_col_enc[3]) begin
            r_row   <= w_row_enc[2:0];
            r_col   <= w_col_enc[2:0];
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_PEND;
          end else if (w_press) begin
            r_err_pulse <= 1'b1;
            r_err_code  <= {~w_col_enc[3], ~w_row_enc[3]};
            r_busy      <= 1'b1;
            r_state     <= S_WAIT_REL;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PEND: begin
          if (r_valid && move_ready) begin
            r_valid <= 1'b0;
            r_count <= (r_count == 8'd255) ? 8'd255 : r_count + 8'd1;
            r_state <= S_WAIT_REL;
          end else begin
            r_state <= S_PEND;
          end
        end
        S_WAIT_REL: begin
          // one move per press: the debounced button must drop before re-arming
          if (!r_btn_db) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT_REL;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign move_valid = r_valid;
  assign move_row   = r_row;
  assign move_col   = r_col;
  assign err_pulse  = r_err_pulse;
  assign err_code   = r_err_code;
  assign move_count = r_count;
  assign busy       = r_busy;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl; expected moves are queued at press time and
// checked when the DUT offers them on the handshake.
module tb_move_input_ctrl;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       Reset_n, BtnU, move_ready;
  logic [7:0] Row, Col;
  logic       move_valid, err_pulse, busy;
  logic [2:0] move_row, move_col;
  logic [1:0] err_code;
  logic [7:0] move_count;

  int         total = 0;
  int         bad = 0;
  int         exp_count = 0;
  logic [5:0] sb_q[$];

  move_input_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_CNT_W(3)) dut (
    .clk(clk), .Reset_n(Reset_n), .BtnU(BtnU), .Row(Row), .Col(Col),
    .move_valid(move_valid), .move_ready(move_ready), .move_row(move_row),
    .move_col(move_col), .err_pulse(err_pulse), .err_code(err_code),
    .move_count(move_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, move_valid, 0);
    check({tag, "_row"}, move_row, 0);
    check({tag, "_col"}, move_col, 0);
    check({tag, "_err"}, err_pulse, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_count"}, move_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // switches settle, then the button goes high right after the returned edge
  task automatic press(input logic [7:0] r, input logic [7:0] c);
    Row = r;
    Col = c;
    cyc(3);
    BtnU = 1'b1;
  endtask

  task automatic release_btn();
    BtnU = 1'b0;
    cyc(DB + 6);
  endtask

  task automatic push_move(input int ri, input int ci);
    sb_q.push_back({3'(ri), 3'(ci)});
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!move_valid && n < budget) begin
      cyc(1);
      n++;
    end
    check({tag, "_seen"}, move_valid, 1);
  endtask

  task automatic wait_accept(input string tag, input int budget);
    int n = 0;
    logic [5:0] e;
    while (!(move_valid && move_ready) && n < budget) begin
      cyc(1);
      n++;
    end
    check({tag, "_accept"}, move_valid && move_ready, 1);
    if (move_valid && move_ready) begin
      check({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 6'd0;
      check({tag, "_row"}, move_row, e[5:3]);
      check({tag, "_col"}, move_col, e[2:0]);
      cyc(1);
      if (exp_count < 255) exp_count++;
      check({tag, "_drop"}, move_valid, 0);
      check({tag, "_count"}, move_count, exp_count);
    end
  endtask

  initial begin
    int hi[3] = '{1, 3, 2};
    logic [7:0] ir[3] = '{8'h00, 8'h11, 8'h01};
    logic [7:0] ic[3] = '{8'h03, 8'h01, 8'h00};
    logic [1:0] icode[3] = '{2'b11, 2'b01, 2'b10};
    int rises;

    Reset_n = 1'b0; BtnU = 1'b0; move_ready = 1'b0; Row = 8'h04; Col = 8'h80;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    Reset_n = 1'b1;
    cyc(2);

    // valid move with exact latency k+3+DB
    move_ready = 1'b1;
    BtnU = 1'b1;
    push_move(2, 7);
    cyc(DB + 2);
    check("t1_early_valid", move_valid, 0);
    cyc(1);
    check("t1_valid", move_valid, 1);
    check("t1_busy", busy, 1);
    wait_accept("t1", 1);
    release_btn();
    check("t1_idle_busy", busy, 0);

    // bounce rejection, then stable high gives exactly one move
    Row = 8'h10; Col = 8'h02;
    cyc(3);
    foreach (hi[i]) begin
      BtnU = 1'b1;
      cyc(hi[i]);
      BtnU = 1'b0;
      cyc(2);
    end
    BtnU = 1'b1;
    push_move(4, 1);
    cyc(DB + 2);
    check("bounce_early_valid", move_valid, 0);
    cyc(1);
    check("bounce_valid", move_valid, 1);
    wait_accept("bounce", 1);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (move_valid) rises++;
    end
    check("hold_no_second", rises, 0);
    release_btn();

    // invalid switch patterns
    foreach (ir[i]) begin
      press(ir[i], ic[i]);
      cyc(DB + 2);
      check("inv_early_err", err_pulse, 0);
      cyc(1);
      check("inv_err", err_pulse, 1);
      check("inv_code", err_code, icode[i]);
      check("inv_valid", move_valid, 0);
      cyc(1);
      check("inv_err_width", err_pulse, 0);
      check("inv_code_hold", err_code, icode[i]);
      rises = 0;
      for (int j = 0; j < 8; j++) begin
        cyc(1);
        if (move_valid || err_pulse) rises++;
      end
      check("inv_quiet", rises, 0);
      check("inv_count", move_count, exp_count);
      release_btn();
    end

    // backpressure: frozen move while switches change
    move_ready = 1'b0;
    press(8'h80, 8'h01);
    push_move(7, 0);
    wait_valid("bp", DB + 10);
    Row = 8'h01; Col = 8'h40;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (!move_valid || move_row != 3'd7 || move_col != 3'd0) rises++;
    end
    check("bp_frozen", rises, 0);
    check("bp_count", move_count, exp_count);
    move_ready = 1'b1;
    wait_accept("bp", 1);
    release_btn();

    // saturation
    for (int i = 0; i < 256; i++) begin
      press(8'd1 << (i % 8), 8'd1 << ((i * 3) % 8));
      push_move(i % 8, (i * 3) % 8);
      wait_accept("sat", DB + 10);
      release_btn();
    end
    check("sat_final", move_count, 255);

    // async reset while a move is pending
    move_ready = 1'b0;
    press(8'h02, 8'h04);
    wait_valid("ar", DB + 10);
    #2;
    Reset_n = 1'b0;
    BtnU = 1'b0;
    #1;
    check_all_zero("async_rst");
    sb_q.delete();
    exp_count = 0;
    @(posedge clk); #1;
    Reset_n = 1'b1;
    cyc(2);
    move_ready = 1'b1;
    press(8'h01, 8'h80);
    push_move(0, 7);
    wait_accept("post_rst", DB + 10);
    release_btn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
